// File: rtl/aria_pkg.sv
// Shared ARIA control definitions: FSM states, key-size codes and round counts.
// No logic; every helper is purely combinational.
package aria_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KINIT = 3'd1,
    ST_KGEN  = 3'd2,
    ST_KLAST = 3'd3,
    ST_RUN   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  localparam logic [1:0] KSIZE_128 = 2'b01;
  localparam logic [1:0] KSIZE_192 = 2'b10;
  localparam logic [1:0] KSIZE_256 = 2'b11;

  localparam int NR_128 = 12;
  localparam int NR_192 = 14;
  localparam int NR_256 = 16;

  // The illegal code 00 never reaches a registered key size, so it shares the 128 count.
  function automatic int nr_of(input logic [1:0] ksize);
    case (ksize)
      KSIZE_192: nr_of = NR_192;
      KSIZE_256: nr_of = NR_256;
      default:   nr_of = NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aria_rk_addr.sv
// Round-key index counter plus the encrypt/decrypt address mux.
// The index saturates at the largest round count and updates one cycle after clr/en; the address is combinational.
module aria_rk_addr
  import aria_pkg::*;
#(
  parameter int RK_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RK_AW-1:0] nr_max,
  input  logic             dec,
  input  logic             clr,
  input  logic             en,
  output logic [RK_AW-1:0] addr
);

  localparam logic [RK_AW-1:0] IDX_MAX = RK_AW'(NR_256);

  logic [RK_AW-1:0] rk_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_idx <= '0;
    end else if (clr) begin
      rk_idx <= '0;
    end else if (en && rk_idx != IDX_MAX) begin
      rk_idx <= rk_idx + 1'b1;
    end
  end

  // Decryption walks the schedule backwards from Nr, computed at address width.
  assign addr = dec ? (nr_max - rk_idx) : rk_idx;

endmodule

// File: rtl/aria_ctrl.sv
// ARIA top-level control FSM: key init, round-key generation and round sequencing.
// Requests arriving while busy are dropped with a one-cycle o_err pulse; the operation in flight continues.
module aria_ctrl
  import aria_pkg::*;
#(
  parameter int RK_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_key_load,
  input  logic [1:0]       i_ksize,
  input  logic             i_start,
  input  logic             i_dec,
  input  logic             flg_klast,
  input  logic             flg_rlast,
  input  logic             flg_ltinv,
  output logic             nr_clr,
  output logic             nr_en,
  output logic [1:0]       st_ksize,
  output logic             ks_load,
  output logic             ks_en,
  output logic             rk_we,
  output logic [RK_AW-1:0] rk_addr,
  output logic             din_load,
  output logic             rnd_en,
  output logic             rnd_odd,
  output logic             rnd_last,
  output logic             fin_en,
  output logic             o_busy,
  output logic             o_key_rdy,
  output logic             o_done,
  output logic             o_err
);

  state_t           state_q, state_d;
  logic             dec_q;
  logic [RK_AW-1:0] nr_max;
  logic [RK_AW-1:0] idx_addr;
  logic             idx_clr, idx_en, idx_dec;
  logic             clr_c, en_c;
  logic             key_ok, start_ok, err_c;

  assign nr_max = RK_AW'(nr_of(st_ksize));
  assign o_busy = (state_q != ST_IDLE);

  aria_rk_addr #(.RK_AW(RK_AW)) u_rk_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .nr_max (nr_max),
    .dec    (idx_dec),
    .clr    (idx_clr),
    .en     (idx_en),
    .addr   (idx_addr)
  );

  always_comb begin
    state_d  = state_q;
    clr_c    = 1'b0;
    en_c     = 1'b0;
    idx_clr  = 1'b0;
    idx_en   = 1'b0;
    idx_dec  = 1'b0;
    key_ok   = 1'b0;
    start_ok = 1'b0;
    err_c    = 1'b0;
    ks_load  = 1'b0;
    ks_en    = 1'b0;
    rk_we    = 1'b0;
    rk_addr  = '0;
    din_load = 1'b0;
    rnd_en   = 1'b0;
    rnd_odd  = 1'b0;
    rnd_last = 1'b0;
    fin_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A key load always takes precedence; a simultaneous start is dropped and flagged.
        if (i_key_load) begin
          err_c = i_start | (i_ksize == 2'b00);
          if (i_ksize != 2'b00) begin
            key_ok  = 1'b1;
            ks_load = 1'b1;
            clr_c   = 1'b1;
            idx_clr = 1'b1;
            state_d = ST_KINIT;
          end
        end else if (i_start) begin
          if (o_key_rdy) begin
            start_ok = 1'b1;
            din_load = 1'b1;
            clr_c    = 1'b1;
            idx_clr  = 1'b1;
            state_d  = ST_RUN;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      ST_KINIT: begin
        ks_en = 1'b1;
        if (flg_klast) begin
          clr_c   = 1'b1;
          state_d = ST_KGEN;
        end else begin
          en_c = 1'b1;
        end
      end
      ST_KGEN: begin
        rk_we   = 1'b1;
        rk_addr = idx_addr;
        idx_en  = 1'b1;
        en_c    = 1'b1;
        if (flg_rlast) begin
          clr_c   = 1'b1;
          state_d = ST_KLAST;
        end
      end
      ST_KLAST: begin
        rk_we   = 1'b1;
        rk_addr = nr_max;
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        rnd_en   = 1'b1;
        rnd_odd  = ~flg_ltinv;
        rnd_last = flg_rlast;
        idx_dec  = dec_q;
        rk_addr  = idx_addr;
        idx_en   = 1'b1;
        en_c     = 1'b1;
        if (flg_rlast) begin
          clr_c   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        fin_en  = 1'b1;
        rk_addr = dec_q ? '0 : nr_max;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      err_c = i_key_load | i_start;
    end

    nr_clr = clr_c;
    nr_en  = en_c & ~clr_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      st_ksize  <= 2'b00;
      dec_q     <= 1'b0;
      o_key_rdy <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_done  <= (state_q == ST_FIN);
      o_err   <= err_c;
      if (key_ok) begin
        st_ksize  <= i_ksize;
        o_key_rdy <= 1'b0;
      end else if (state_q == ST_KLAST) begin
        o_key_rdy <= 1'b1;
      end
      if (start_ok) begin
        dec_q <= i_dec;
      end
    end
  end

endmodule
